// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: RegFile write-port arbiter (WB vs long-latency unit) with pending-register scoreboard
module regfile_wb_arbiter #(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    output logic        wb_hold,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        stall,
    output logic        WE,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [2:0]  busy_cnt
);
    typedef enum logic {PRI_WB, PRI_LU} state_t;
    localparam logic [2:0] MAX_C = 3'(MAX_OUT);
    localparam logic [2:0] LIM_C = 3'(STARVE_LIM);
    state_t      state;
    logic [2:0]  starve, starve_n;
    logic [31:1] busy;
    logic [31:0] busy_v, set_v, clr_v;
    logic        wb_own, lu_own, iss_acc, lu_acc;
    // Grant, scoreboard lookups and next-state terms, all from current inputs and state
    always_comb begin
        busy_v    = {busy, 1'b0};
        lu_own    = !rst && lu_valid && (state == PRI_LU || !wb_we);
        wb_own    = !rst && wb_we && !lu_own;
        lu_ready  = lu_own;
        wb_hold   = lu_own && wb_we;
        WE        = lu_own ? (lu_waddr != 5'd0) : (wb_own && wb_waddr != 5'd0);
        waddr     = lu_own ? lu_waddr : wb_own ? wb_waddr : 5'd0;
        wdata     = lu_own ? lu_wdata : wb_own ? wb_wdata : 32'd0;
        iss_ready = !rst && busy_cnt < MAX_C && !busy_v[iss_rd];
        stall     = !rst && ((rs1 != 5'd0 && busy_v[rs1]) || (rs2 != 5'd0 && busy_v[rs2]) ||
                             (wb_we && wb_waddr != 5'd0 && busy_v[wb_waddr]));
        iss_acc   = iss_valid && iss_ready;
        lu_acc    = lu_valid && lu_ready;
        set_v     = (iss_acc && iss_rd != 5'd0) ? 32'd1 << iss_rd : 32'd0;
        clr_v     = lu_acc ? 32'd1 << lu_waddr : 32'd0;
        starve_n  = (lu_valid && !lu_ready) ? ((starve >= LIM_C) ? LIM_C : starve + 3'd1) : 3'd0;
    end
    // Priority FSM, starvation counter, busy bits and outstanding-op count
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PRI_WB;
            starve   <= 3'd0;
            busy     <= '0;
            busy_cnt <= 3'd0;
        end else begin
            state    <= (state == PRI_WB && lu_valid && starve_n == LIM_C) ? PRI_LU : PRI_WB;
            starve   <= starve_n;
            busy     <= (busy & ~clr_v[31:1]) | set_v[31:1];
            busy_cnt <= (iss_acc && !lu_acc && busy_cnt < MAX_C) ? busy_cnt + 3'd1 :
                        (lu_acc && !iss_acc && busy_cnt != 3'd0) ? busy_cnt - 3'd1 : busy_cnt;
        end
    end
endmodule
